// File: rtl/soc_system_pkg.sv
// rtl/soc_system_pkg.sv - shared types and constants for the soc_system bus controller
//
// Contents:
//   bus_state_e    external SRAM access sequencer states
//   target_e       decoded target of a CPU memory access
//   cpu_state_e    states of the embedded CPU core's walk loop
//   BASE_REGION / EXT_REGION / DEBUG_ADDR   physical address map
//   decode_target  maps a word address (phys[28:2]) onto a target
package soc_system_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } bus_state_e;

    typedef enum logic [1:0] {
        TGT_BASE,
        TGT_EXT,
        TGT_DEBUG,
        TGT_NONE
    } target_e;

    typedef enum logic [1:0] {
        CPU_LOAD,
        CPU_STORE,
        CPU_NEXT
    } cpu_state_e;

    localparam logic [6:0]  BASE_REGION = 7'd0;
    localparam logic [6:0]  EXT_REGION  = 7'd1;
    localparam logic [28:0] DEBUG_ADDR  = 29'h1FD0_0000;

    // word_addr is phys[28:2]; byte-lane bits never take part in decode.
    // The debug register wins over region decode should the two ever overlap.
    function automatic target_e decode_target(input logic [26:0] word_addr,
                                              input logic [28:0] debug_addr);
        if (word_addr == debug_addr[28:2]) begin
            return TGT_DEBUG;
        end else if (word_addr[26:20] == BASE_REGION) begin
            return TGT_BASE;
        end else if (word_addr[26:20] == EXT_REGION) begin
            return TGT_EXT;
        end else begin
            return TGT_NONE;
        end
    endfunction

endpackage

// File: rtl/soc_system_bus_ctrl.sv
// rtl/soc_system_bus_ctrl.sv - CPU-port to dual asynchronous SRAM bus controller
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   word_addr[26:0]                  CPU physical word address (phys[28:2])
//   mem_rd / mem_wr                  CPU request strobes (both high = write)
//   mem_wdata[31:0]                  CPU write data
//   mem_rdata[31:0]                  registered read data to the CPU
//   mem_busy                         request outstanding, low in DONE
//   debug_value[31:0]                current debug register, returned on reads
//   debug_we                         one-cycle load strobe for the debug register
//   base_* / ext_*                   SRAM address, tristate data, active-low ce/oe/we
module soc_system_bus_ctrl #(
    parameter logic [28:0] DEBUG_ADDR = soc_system_pkg::DEBUG_ADDR,
    parameter int          RAM_AW     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [26:0]       word_addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_busy,
    input  logic [31:0]       debug_value,
    output logic              debug_we,
    output logic [RAM_AW-1:0] base_addr,
    inout  wire  [31:0]       base_data,
    output logic              base_ce,
    output logic              base_oe,
    output logic              base_we,
    output logic [RAM_AW-1:0] ext_addr,
    inout  wire  [31:0]       ext_data,
    output logic              ext_ce,
    output logic              ext_oe,
    output logic              ext_we
);
    import soc_system_pkg::*;

    bus_state_e  state;
    target_e     target;
    logic        req;
    logic        sel_ext;
    logic        base_drive;
    logic        ext_drive;
    logic [31:0] wdata_q;

    assign target = decode_target(word_addr, DEBUG_ADDR);
    assign req    = mem_rd | mem_wr;

    // Drive enables are registers, so reset releases the buses without a clock.
    assign base_data = base_drive ? wdata_q : 32'bz;
    assign ext_data  = ext_drive  ? wdata_q : 32'bz;

    // The debug register loads on the edge that ends the request cycle.
    assign debug_we = rst_n & (state == ST_IDLE) & mem_wr & (target == TGT_DEBUG);

    // Busy covers the request cycle itself, hence the combinational IDLE term.
    assign mem_busy = rst_n & (((state == ST_IDLE) & req) |
                               (state == ST_RD) | (state == ST_WR1) | (state == ST_WR2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel_ext    <= 1'b0;
            wdata_q    <= '0;
            mem_rdata  <= '0;
            base_addr  <= '0;
            ext_addr   <= '0;
            base_ce    <= 1'b1;
            base_oe    <= 1'b1;
            base_we    <= 1'b1;
            ext_ce     <= 1'b1;
            ext_oe     <= 1'b1;
            ext_we     <= 1'b1;
            base_drive <= 1'b0;
            ext_drive  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        case (target)
                            TGT_BASE, TGT_EXT: begin
                                sel_ext <= (target == TGT_EXT);
                                wdata_q <= mem_wdata;
                                if (target == TGT_EXT) begin
                                    ext_addr <= word_addr[RAM_AW-1:0];
                                    ext_ce   <= 1'b0;
                                end else begin
                                    base_addr <= word_addr[RAM_AW-1:0];
                                    base_ce   <= 1'b0;
                                end
                                if (mem_wr) begin
                                    state <= ST_WR1;
                                    if (target == TGT_EXT) ext_drive  <= 1'b1;
                                    else                   base_drive <= 1'b1;
                                end else begin
                                    state <= ST_RD;
                                    if (target == TGT_EXT) ext_oe  <= 1'b0;
                                    else                   base_oe <= 1'b0;
                                end
                            end
                            TGT_DEBUG: begin
                                if (!mem_wr) mem_rdata <= debug_value;
                                state <= ST_DONE;
                            end
                            default: begin
                                if (!mem_wr) mem_rdata <= '0;
                                state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    mem_rdata <= sel_ext ? ext_data : base_data;
                    state     <= ST_DONE;
                end
                ST_WR1: begin
                    if (sel_ext) ext_we  <= 1'b0;
                    else         base_we <= 1'b0;
                    state <= ST_WR2;
                end
                ST_WR2: begin
                    // Data stays driven into DONE to give the SRAM hold time.
                    base_we <= 1'b1;
                    ext_we  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    base_ce    <= 1'b1;
                    base_oe    <= 1'b1;
                    base_we    <= 1'b1;
                    ext_ce     <= 1'b1;
                    ext_oe     <= 1'b1;
                    ext_we     <= 1'b1;
                    base_drive <= 1'b0;
                    ext_drive  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/soc_system_cpu.sv
// rtl/soc_system_cpu.sv - minimal CPU core: walks base SRAM words doing read-increment-write
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_addr[31:0]             byte address of the current request
//   mem_rd / mem_wr            request strobes, held until mem_busy is seen low
//   mem_wdata[31:0]            write data
//   mem_rdata[31:0]            read data, valid in the cycle mem_busy drops
//   mem_busy                   high while the current request is outstanding
module soc_system_cpu (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
);
    import soc_system_pkg::*;

    cpu_state_e state;
    logic [7:0] word;

    assign mem_addr = {22'd0, word, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CPU_LOAD;
            word      <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                CPU_LOAD: begin
                    if (!mem_rd) begin
                        mem_rd <= 1'b1;
                    end else if (!mem_busy) begin
                        mem_rd    <= 1'b0;
                        mem_wdata <= mem_rdata + 32'd1;
                        state     <= CPU_STORE;
                    end
                end
                CPU_STORE: begin
                    if (!mem_wr) begin
                        mem_wr <= 1'b1;
                    end else if (!mem_busy) begin
                        mem_wr <= 1'b0;
                        state  <= CPU_NEXT;
                    end
                end
                CPU_NEXT: begin
                    word  <= word + 8'd1;
                    state <= CPU_LOAD;
                end
                default: state <= CPU_LOAD;
            endcase
        end
    end

endmodule

// File: rtl/soc_system.sv
// rtl/soc_system.sv - system top: CPU core, SRAM bus controller and debug register
//
// Ports:
//   clk                      system clock
//   rst                      asynchronous active-low reset (also resets the CPU)
//   debug_out[31:0]          memory-mapped debug register
//   baseram_addr/data        base SRAM word address and tristate data bus
//   baseram_ce/oe/we         base SRAM active-low controls
//   extram_addr/data         ext SRAM word address and tristate data bus
//   extram_ce/oe/we          ext SRAM active-low controls
module soc_system #(
    parameter logic [28:0] DEBUG_ADDR = soc_system_pkg::DEBUG_ADDR,
    parameter int          RAM_AW     = 20
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       debug_out,
    output logic [RAM_AW-1:0] baseram_addr,
    inout  wire  [31:0]       baseram_data,
    output logic              baseram_ce,
    output logic              baseram_oe,
    output logic              baseram_we,
    output logic [RAM_AW-1:0] extram_addr,
    inout  wire  [31:0]       extram_data,
    output logic              extram_ce,
    output logic              extram_oe,
    output logic              extram_we
);
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        debug_we;
    logic        addr_unused;

    // Segment bits and byte-lane bits are ignored by the memory map.
    assign addr_unused = ^{mem_addr[31:29], mem_addr[1:0]};

    soc_system_cpu ucpu (
        .clk       (clk),
        .rst_n     (rst),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_busy  (mem_busy)
    );

    soc_system_bus_ctrl #(
        .DEBUG_ADDR (DEBUG_ADDR),
        .RAM_AW     (RAM_AW)
    ) u_bus (
        .clk         (clk),
        .rst_n       (rst),
        .word_addr   (mem_addr[28:2]),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_busy    (mem_busy),
        .debug_value (debug_out),
        .debug_we    (debug_we),
        .base_addr   (baseram_addr),
        .base_data   (baseram_data),
        .base_ce     (baseram_ce),
        .base_oe     (baseram_oe),
        .base_we     (baseram_we),
        .ext_addr    (extram_addr),
        .ext_data    (extram_data),
        .ext_ce      (extram_ce),
        .ext_oe      (extram_oe),
        .ext_we      (extram_we)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            debug_out <= '0;
        end else if (debug_we) begin
            debug_out <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_soc_system.sv
// tb/tb_soc_system.sv - self-checking bench for soc_system with SRAM device models
module tb_soc_system;

    localparam logic [28:0] DBG = 29'h1FD0_0000;

    logic        clk;
    logic        rst;
    logic [31:0] debug_out;
    logic [19:0] baseram_addr;
    wire  [31:0] baseram_data;
    logic        baseram_ce, baseram_oe, baseram_we;
    logic [19:0] extram_addr;
    wire  [31:0] extram_data;
    logic        extram_ce, extram_oe, extram_we;

    logic [31:0] base_dev [64];
    logic [31:0] ext_dev  [64];
    logic [31:0] ref_base [64];
    logic [31:0] ref_ext  [64];
    logic [31:0] ref_debug;

    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;

    int n_checks;
    int n_errors;

    soc_system dut (
        .clk          (clk),
        .rst          (rst),
        .debug_out    (debug_out),
        .baseram_addr (baseram_addr),
        .baseram_data (baseram_data),
        .baseram_ce   (baseram_ce),
        .baseram_oe   (baseram_oe),
        .baseram_we   (baseram_we),
        .extram_addr  (extram_addr),
        .extram_data  (extram_data),
        .extram_ce    (extram_ce),
        .extram_oe    (extram_oe),
        .extram_we    (extram_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM devices: combinational read, a write lands when ce and we are seen low at a clock edge.
    assign baseram_data = (baseram_ce == 1'b0 && baseram_oe == 1'b0) ? base_dev[baseram_addr[5:0]] : 32'bz;
    assign extram_data  = (extram_ce  == 1'b0 && extram_oe  == 1'b0) ? ext_dev[extram_addr[5:0]]   : 32'bz;

    always @(posedge clk) begin
        if (baseram_ce == 1'b0 && baseram_we == 1'b0) base_dev[baseram_addr[5:0]] = baseram_data;
        if (extram_ce == 1'b0 && extram_we == 1'b0)   ext_dev[extram_addr[5:0]]   = extram_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 = base SRAM, 1 = ext SRAM, 2 = debug register, 3 = unmapped
    function automatic int classify(input logic [31:0] a);
        logic [28:0] phys;
        phys = a[28:0];
        if ((phys >> 2) == (DBG >> 2)) return 2;
        if ((phys >> 22) == 29'd0) return 0;
        if ((phys >> 22) == 29'd1) return 1;
        return 3;
    endfunction

    function automatic logic [31:0] make_addr(input int kind, input int word);
        logic [2:0]  seg;
        logic [1:0]  lane;
        logic [6:0]  region;
        logic [19:0] far;
        seg    = 3'($urandom);
        lane   = 2'($urandom);
        region = 7'($urandom_range(2, 126));
        far    = 20'($urandom);
        case (kind)
            0:       return {seg, 7'd0, 14'd0, 6'(word), lane};
            1:       return {seg, 7'd1, 14'd0, 6'(word), lane};
            2:       return {seg, DBG[28:2], lane};
            default: return {seg, region, far, lane};
        endcase
    endfunction

    // Starts just after a rising edge with the controller idle; returns just after a rising edge.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wdata);
        int          kind, word, exp_lat, we_low;
        bit          done, sram;
        logic [31:0] exp_rdata;
        logic [2:0]  sel_ctl, oth_ctl;
        logic [31:0] sel_bus;
        logic [19:0] sel_addr;
        kind    = classify(addr);
        word    = int'(addr[7:2]);
        sram    = (kind < 2);
        exp_lat = sram ? (wr ? 3 : 2) : 1;
        case (kind)
            0:       exp_rdata = ref_base[word];
            1:       exp_rdata = ref_ext[word];
            2:       exp_rdata = ref_debug;
            default: exp_rdata = 32'd0;
        endcase
        if (wr) begin
            case (kind)
                0:       ref_base[word] = wdata;
                1:       ref_ext[word]  = wdata;
                2:       ref_debug      = wdata;
                default: ;
            endcase
        end
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        req_wr    = wr;
        we_low    = 0;
        done      = 0;
        for (int cyc = 0; cyc < 8 && !done; cyc++) begin
            @(negedge clk);
            sel_ctl  = (kind == 1) ? {extram_ce, extram_oe, extram_we} : {baseram_ce, baseram_oe, baseram_we};
            oth_ctl  = (kind == 1) ? {baseram_ce, baseram_oe, baseram_we} : {extram_ce, extram_oe, extram_we};
            sel_bus  = (kind == 1) ? extram_data : baseram_data;
            sel_addr = (kind == 1) ? extram_addr : baseram_addr;
            check("oe_we_excl", {30'd0, (!baseram_oe && !baseram_we), (!extram_oe && !extram_we)}, 32'd0);
            if (sram) check("unsel_ctl", {29'd0, oth_ctl}, 32'd7);
            else      check("no_ram_ctl", {26'd0, sel_ctl, oth_ctl}, 32'h3F);
            if (sram && !wr && cyc == 1) begin
                check("rd_ctl", {29'd0, sel_ctl}, 32'd1);
                check("rd_addr", {12'd0, sel_addr}, {12'd0, addr[21:2]});
            end
            if (sram && wr && cyc >= 1) begin
                check("wr_data", sel_bus, wdata);
                if (cyc <= 2) check("wr_ce_oe", {30'd0, sel_ctl[2:1]}, 32'd1);
                if (cyc == 1) check("wr_addr", {12'd0, sel_addr}, {12'd0, addr[21:2]});
                if (sel_ctl[0] == 1'b0) begin
                    we_low++;
                    check("we_low_cycle", cyc, 32'd2);
                end
            end
            if (dut.mem_busy == 1'b0) begin
                done = 1;
                check("latency", cyc, exp_lat);
                if (!wr) check("rdata", dut.mem_rdata, exp_rdata);
                check("debug_out", debug_out, ref_debug);
            end
        end
        if (!done) check("busy_timeout", 32'd1, 32'd0);
        if (sram && wr) check("we_low_count", we_low, 32'd1);
        @(posedge clk);
        #1;
        req_rd = 1'b0;
        req_wr = 1'b0;
        @(negedge clk);
        check("idle_ctl", {26'd0, baseram_ce, baseram_oe, baseram_we, extram_ce, extram_oe, extram_we}, 32'h3F);
        check("idle_drive", {30'd0, dut.u_bus.base_drive, dut.u_bus.ext_drive}, 32'd0);
        check("idle_busy", {31'd0, dut.mem_busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_write();
        logic [31:0] newval;
        newval    = ~ref_base[7];
        req_addr  = 32'h0000_001C;
        req_wdata = newval;
        req_wr    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_we_low", {31'd0, baseram_we}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_we", {31'd0, baseram_we}, 32'd1);
        check("rst_ce_oe", {30'd0, baseram_ce, baseram_oe}, 32'd3);
        check("rst_drive", {31'd0, dut.u_bus.base_drive}, 32'd0);
        check("rst_busy", {31'd0, dut.mem_busy}, 32'd0);
        check("rst_addr", {12'd0, baseram_addr}, 32'd0);
        check("rst_rdata", dut.mem_rdata, 32'd0);
        check("rst_debug", debug_out, 32'd0);
        ref_debug = 32'd0;
        req_wr    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ram_word", base_dev[7], ref_base[7]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_access(1'b0, 1'b1, 32'h0000_001C, 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        int          kind, word, op;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        ref_debug = 32'd0;
        force dut.mem_rd    = req_rd;
        force dut.mem_wr    = req_wr;
        force dut.mem_addr  = req_addr;
        force dut.mem_wdata = req_wdata;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            base_dev[i] = v;
            ref_base[i] = v;
            v = $urandom;
            ext_dev[i] = v;
            ref_ext[i] = v;
        end
        base_dev[5] = 32'hDEAD_BEEF;
        ref_base[5] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check("reset_ctl", {26'd0, baseram_ce, baseram_oe, baseram_we, extram_ce, extram_oe, extram_we}, 32'h3F);
        check("reset_drive", {30'd0, dut.u_bus.base_drive, dut.u_bus.ext_drive}, 32'd0);
        check("reset_debug", debug_out, 32'd0);
        check("reset_busy", {31'd0, dut.mem_busy}, 32'd0);
        check("reset_rdata", dut.mem_rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_access(1'b0, 1'b1, 32'h0000_0014, 32'd0);
        run_access(1'b1, 1'b0, 32'h0040_0008, 32'h1234_5678);
        check("ext_dev_word2", ext_dev[2], 32'h1234_5678);
        run_access(1'b0, 1'b1, 32'h0040_0008, 32'd0);
        run_access(1'b1, 1'b0, 32'h1FD0_0000, 32'h0000_00A5);
        run_access(1'b0, 1'b1, 32'hBFD0_0000, 32'd0);
        run_access(1'b0, 1'b1, 32'h1000_0000, 32'd0);
        run_access(1'b1, 1'b0, 32'h1000_0000, 32'h5555_AAAA);
        run_access(1'b1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D);
        run_access(1'b0, 1'b1, 32'h0000_0024, 32'd0);
        reset_mid_write();

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            word = $urandom_range(0, 63);
            op   = $urandom_range(0, 9);
            if (op == 0)     run_access(1'b1, 1'b1, make_addr(kind, word), $urandom);
            else if (op < 5) run_access(1'b0, 1'b1, make_addr(kind, word), 32'd0);
            else             run_access(1'b1, 1'b0, make_addr(kind, word), $urandom);
        end

        for (int i = 0; i < 64; i++) begin
            check("final_base", base_dev[i], ref_base[i]);
            check("final_ext", ext_dev[i], ref_ext[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/soc_system.md
Name: soc_system

Overview:
- Top-level system block: wraps the existing CPU core (instance ucpu) and implements the bus controller between the CPU memory port and two external asynchronous 32-bit SRAMs (base and ext).
- Also holds a memory-mapped debug register driven onto debug_out.
- The block is one clock domain; the SRAMs are external, combinational-read devices.

Parameters:
- DEBUG_ADDR, 29'h1FD0_0000: physical address of the debug register.
- RAM_AW, 20: SRAM word-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset); also drives the CPU reset.
- debug_out  out  32  debug register value.
- baseram_addr  out  20  base SRAM word address.
- baseram_data  inout  32  base SRAM data bus, tristated.
- baseram_ce / baseram_oe / baseram_we  out  1 each  active-low base SRAM controls.
- extram_addr / extram_data / extram_ce / extram_oe / extram_we: same as above, for the ext SRAM.

Behaviour:
- CPU port, internal to the block: mem_addr[31:0], mem_rd, mem_wr, mem_wdata[31:0] from ucpu; mem_rdata[31:0] and mem_busy to ucpu.
  - The CPU holds its request stable while mem_busy=1.
  - Word accesses only; mem_addr[1:0] is ignored.
- Address decode: phys = mem_addr[28:0].
  - phys[28:22]==0 selects baseram; baseram_addr = phys[21:2].
  - phys[28:22]==1 selects extram; extram_addr = phys[21:2].
  - phys==DEBUG_ADDR selects the debug register.
  - Any other address: reads return 0, writes are dropped, access completes in 1 cycle.
- Simultaneous mem_rd and mem_wr: the access is treated as a write.
- FSM states: IDLE, RD, WR1, WR2, DONE.
  - IDLE, request to SRAM: latch address/data. A read goes to RD (ce=0, oe=0); a write goes to WR1 (ce=0, data driven, we=1).
  - RD: sample the selected data bus into mem_rdata at the clock edge, then DONE. Read latency is 2 cycles from request to data.
  - WR1 -> WR2: we=0 for exactly one cycle in WR2, data held stable.
  - WR2 -> DONE: we=1; data stays driven through DONE for hold time.
  - DONE: deassert ce/oe/we and release the bus, then IDLE.
  - mem_busy = 1 from the request cycle until the cycle before DONE; deasserts in DONE.
  - Debug register and unmapped accesses go IDLE -> DONE.
- Debug register:
  - A write loads mem_wdata into debug_out at the clock edge.
  - A read returns the current debug_out.
- Bus rules:
  - The data bus is driven only during WR1/WR2/DONE of a write, and only on the selected RAM; otherwise hi-Z.
  - The non-selected RAM keeps ce=oe=we=1 throughout.
  - oe and we are never both 0.
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all ce/oe/we go to 1; both data buses hi-Z.
  - debug_out=0, mem_rdata=0, mem_busy=0.
  - An access in progress is aborted with no write completed; addresses go to 0.
  - Normal operation resumes on the first clk edge after rst=1.

Decomposition:
- Shared package: FSM state enum, region-decode constants (BASE_REGION=7'd0, EXT_REGION=7'd1, DEBUG_ADDR).
- One natural sub-module: bus_ctrl, containing the FSM, decode and tristate control. soc_system instantiates ucpu and bus_ctrl and owns the debug register.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> all ce/oe/we=1, data buses hi-Z, debug_out=0, mem_busy=0.
- Base read: baseram word 5 = 32'hDEADBEEF; CPU read of 0x00000014 -> baseram_addr=5, ce=oe=0 in RD, mem_rdata=DEADBEEF two cycles after the request, extram controls stay 1.
- Ext write then read: write 32'h12345678 to 0x00400008 -> extram_addr=2, extram_we low for exactly 1 cycle with data stable one cycle before and after; a following read returns 12345678.
- Debug register: write 32'h0000_00A5 to 0x1FD00000 -> debug_out=000000A5 on the next edge; a read of 0xBFD00000 returns 000000A5 (top bits ignored).
- Reset mid-access: drop rst during WR2 -> we returns to 1 and the bus goes hi-Z immediately with no clock; the RAM word is unchanged.
- Unmapped address: read 0x10000000 -> returns 0 in 1 cycle; neither RAM's ce is asserted.
